antares_pipeline_ctrl: RTL and testbench

ANTARES_PIPELINE_CTRL -- requirements
Module: antares_pipeline_ctrl

---
 rtl/antares_pipeline_ctrl_if.sv | 40 ++++
 rtl/antares_pipeline_ctrl.sv | 84 ++++++++
 tb/tb_antares_pipeline_ctrl.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/antares_pipeline_ctrl_if.sv
// Pipeline control bundle: hazard/busy inputs in,
// per-stage stall/flush, redirect and perf counter out.
interface antares_pipeline_ctrl_if;
  logic        if_mem_busy;
  logic        mem_mem_busy;
  logic        id_hazard_stall;
  logic        ex_unit_busy;
  logic        exc_request;
  logic        perf_clear;
  logic        if_stall;
  logic        id_stall;
  logic        ex_stall;
  logic        mem_stall;
  logic        if_flush;
  logic        id_flush;
  logic        ex_flush;
  logic        mem_flush;
  logic        pc_redirect;
  logic        ex_unit_abort;
  logic        exc_pending;
  logic [31:0] stall_cycles;

  modport master (
    input  if_mem_busy, mem_mem_busy, id_hazard_stall,
    input  ex_unit_busy, exc_request, perf_clear,
    output if_stall, id_stall, ex_stall, mem_stall,
    output if_flush, id_flush, ex_flush, mem_flush,
    output pc_redirect, ex_unit_abort, exc_pending,
    output stall_cycles
  );

  modport slave (
    output if_mem_busy, mem_mem_busy, id_hazard_stall,
    output ex_unit_busy, exc_request, perf_clear,
    input  if_stall, id_stall, ex_stall, mem_stall,
    input  if_flush, id_flush, ex_flush, mem_flush,
    input  pc_redirect, ex_unit_abort, exc_pending,
    input  stall_cycles
  );
endinterface

// File: rtl/antares_pipeline_ctrl.sv
// Pipeline stall/flush controller: RUN/WAIT_MEM/FLUSH/REFILL FSM,
// ports: clk, rst_n (sync, active-low), bus (master modport).
module antares_pipeline_ctrl (
  input  logic clk,
  input  logic rst_n,
  antares_pipeline_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    WAIT_MEM = 2'd1,
    FLUSH    = 2'd2,
    REFILL   = 2'd3
  } state_t;

  state_t      state_q;
  logic [31:0] cnt_q;

  logic in_wait;
  logic in_flush;
  logic in_refill;
  logic take_exc;
  logic mem_s;
  logic ex_s;
  logic id_s;
  logic if_s;

  // Outputs are forced low while reset is held, even
  // before the synchronous reset edge has landed.
  assign in_wait   = rst_n && (state_q == WAIT_MEM);
  assign in_flush  = rst_n && (state_q == FLUSH);
  assign in_refill = rst_n && (state_q == REFILL);

  assign take_exc = bus.exc_request &&
                    (state_q == RUN || state_q == REFILL);

  // Flush dominates: downstream stalls vanish in FLUSH,
  // leaving if_stall = if_mem_busy.
  assign mem_s = rst_n && !in_flush && bus.mem_mem_busy;
  assign ex_s  = rst_n && !in_flush &&
                 (bus.mem_mem_busy || bus.ex_unit_busy);
  assign id_s  = rst_n && !in_flush &&
                 (bus.mem_mem_busy || bus.ex_unit_busy ||
                  bus.id_hazard_stall);
  assign if_s  = rst_n && (id_s || bus.if_mem_busy);

  assign bus.mem_stall     = mem_s;
  assign bus.ex_stall      = ex_s;
  assign bus.id_stall      = id_s;
  assign bus.if_stall      = if_s;
  assign bus.if_flush      = in_flush;
  assign bus.id_flush      = in_flush || in_refill;
  assign bus.ex_flush      = in_flush;
  assign bus.mem_flush     = in_flush;
  assign bus.pc_redirect   = in_flush;
  assign bus.ex_unit_abort = in_flush;
  assign bus.exc_pending   = in_wait || in_flush;
  assign bus.stall_cycles  = cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      unique case (1'b1)
        take_exc:
          state_q <= bus.mem_mem_busy ? WAIT_MEM : FLUSH;
        state_q == WAIT_MEM:
          if (!bus.mem_mem_busy) state_q <= FLUSH;
        state_q == FLUSH:
          state_q <= bus.if_mem_busy ? REFILL : RUN;
        state_q == REFILL && !bus.exc_request:
          if (!bus.if_mem_busy) state_q <= RUN;
        default: ;
      endcase

      if (bus.perf_clear)
        cnt_q <= '0;
      else if (if_s && !(&cnt_q))
        cnt_q <= cnt_q + 32'd1;
    end
  end

endmodule

// File: tb/tb_antares_pipeline_ctrl.sv
// Scoreboard bench for antares_pipeline_ctrl:
// driver pushes model expectations, monitor compares at negedge.
module tb_antares_pipeline_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  antares_pipeline_ctrl_if bus ();

  antares_pipeline_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [10:0] ctl;
    logic [31:0] cnt;
  } exp_t;

  localparam int MD_RUN    = 0;
  localparam int MD_WAIT   = 1;
  localparam int MD_FLUSH  = 2;
  localparam int MD_REFILL = 3;
  localparam logic [31:0] PRE = 32'hFFFF_FFFD;

  exp_t        sb[$];
  int          mode = MD_RUN;
  logic [31:0] m_cnt = '0;
  bit          preload_req = 1'b0;
  int          tests = 0;
  int          fails = 0;

  task automatic step(input bit r, input bit i, input bit m,
                      input bit h, input bit x, input bit e,
                      input bit c);
    exp_t ex;
    bit fl, rf, wt, ms, es, ds, is;
    @(posedge clk);
    #1;
    if (preload_req) begin
      force dut.cnt_q = PRE;
      release dut.cnt_q;
      m_cnt = PRE;
      preload_req = 1'b0;
    end
    rst_n               = r;
    bus.if_mem_busy     = i;
    bus.mem_mem_busy    = m;
    bus.id_hazard_stall = h;
    bus.ex_unit_busy    = x;
    bus.exc_request     = e;
    bus.perf_clear      = c;
    fl = r && mode == MD_FLUSH;
    rf = r && mode == MD_REFILL;
    wt = r && mode == MD_WAIT;
    ms = r && !fl && m;
    es = r && !fl && (m || x);
    ds = r && !fl && (m || x || h);
    is = r && (fl ? i : (ds || i));
    ex.ctl = {is, ds, es, ms, fl, fl || rf, fl, fl,
              fl, fl, wt || fl};
    ex.cnt = m_cnt;
    sb.push_back(ex);
    if (!r) begin
      mode  = MD_RUN;
      m_cnt = '0;
    end else begin
      if (c)
        m_cnt = '0;
      else if (is && m_cnt != 32'hFFFF_FFFF)
        m_cnt = m_cnt + 1;
      if ((mode == MD_RUN || mode == MD_REFILL) && e)
        mode = m ? MD_WAIT : MD_FLUSH;
      else if (mode == MD_WAIT)
        mode = m ? MD_WAIT : MD_FLUSH;
      else if (mode == MD_FLUSH)
        mode = i ? MD_REFILL : MD_RUN;
      else if (mode == MD_REFILL)
        mode = i ? MD_REFILL : MD_RUN;
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin : monitor
    exp_t e;
    logic [10:0] got;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        got = {bus.if_stall, bus.id_stall, bus.ex_stall,
               bus.mem_stall, bus.if_flush, bus.id_flush,
               bus.ex_flush, bus.mem_flush, bus.pc_redirect,
               bus.ex_unit_abort, bus.exc_pending};
        tests++;
        if (got !== e.ctl) begin
          fails++;
          $display("FAIL ctl t=%0t got=%b exp=%b",
                   $time, got, e.ctl);
        end
        tests++;
        if (bus.stall_cycles !== e.cnt) begin
          fails++;
          $display("FAIL stall_cycles t=%0t got=%h exp=%h",
                   $time, bus.stall_cycles, e.cnt);
        end
      end
    end
  end

  initial begin : driver
    bus.if_mem_busy     = 1'b0;
    bus.mem_mem_busy    = 1'b0;
    bus.id_hazard_stall = 1'b0;
    bus.ex_unit_busy    = 1'b0;
    bus.exc_request     = 1'b0;
    bus.perf_clear      = 1'b0;
    for (int k = 0; k < 3; k++) step(0, 1, 1, 1, 1, 1, 0);
    idle(2);
    // stall chain from the mult/div unit
    for (int k = 0; k < 4; k++) step(1, 0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 1, 0, 0, 0);
    // fast exception
    step(1, 0, 0, 0, 0, 1, 0);
    idle(3);
    // delayed exception, second request ignored
    step(1, 0, 1, 0, 0, 1, 0);
    step(1, 0, 1, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 1, 0);
    step(1, 0, 1, 0, 0, 0, 0);
    idle(4);
    // flush into a two-cycle refill
    step(1, 0, 0, 0, 0, 1, 0);
    step(1, 1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0);
    idle(3);
    // exception during refill wins over return to RUN
    step(1, 0, 0, 0, 0, 1, 0);
    step(1, 1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1, 0);
    idle(4);
    // counter saturation then clear under stall
    preload_req = 1'b1;
    for (int k = 0; k < 5; k++) step(1, 1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 1);
    idle(2);
    // reset while waiting on memory
    step(1, 0, 1, 0, 0, 1, 0);
    step(1, 0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    idle(3);
    // randomized traffic
    for (int k = 0; k < 2000; k++)
      step($urandom_range(99) >= 2,
           $urandom_range(99) < 30,
           $urandom_range(99) < 30,
           $urandom_range(99) < 20,
           $urandom_range(99) < 20,
           $urandom_range(99) < 10,
           $urandom_range(99) < 3);
    repeat (3) @(negedge clk);
    #1;
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain left=%0d exp=0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
